// File: rtl/cr16_pkg.sv
// cr16_pkg: shared definitions for the CR16 control block.
//   - FSM state encodings (also visible on O_STATE)
//   - opcode / ext field constants and decode helpers
//   - branch condition codes and flag bit indices
//   - PC_SRC / RF_SRC mux select encodings
package cr16_pkg;

    localparam int unsigned FlagWidth  = 5;
    localparam int unsigned InstrWidth = 16;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StBranch = 3'd4
    } state_e;

    // Flag vector layout
    localparam int unsigned FlagC = 0;
    localparam int unsigned FlagL = 1;
    localparam int unsigned FlagF = 2;
    localparam int unsigned FlagZ = 3;
    localparam int unsigned FlagN = 4;

    // Opcodes; R-type ALU ext codes reuse the same values as the immediate opcodes
    localparam logic [3:0] OpRtype = 4'b0000;
    localparam logic [3:0] OpAnd   = 4'b0001;
    localparam logic [3:0] OpOr    = 4'b0010;
    localparam logic [3:0] OpXor   = 4'b0011;
    localparam logic [3:0] OpMemJ  = 4'b0100;
    localparam logic [3:0] OpAdd   = 4'b0101;
    localparam logic [3:0] OpShift = 4'b1000;
    localparam logic [3:0] OpSub   = 4'b1001;
    localparam logic [3:0] OpCmp   = 4'b1011;
    localparam logic [3:0] OpBcond = 4'b1100;
    localparam logic [3:0] OpMov   = 4'b1101;
    localparam logic [3:0] OpLui   = 4'b1111;

    // ext field values under OpMemJ and OpShift
    localparam logic [3:0] ExtLoad  = 4'b0000;
    localparam logic [3:0] ExtStor  = 4'b0100;
    localparam logic [3:0] ExtJal   = 4'b1000;
    localparam logic [3:0] ExtJcond = 4'b1100;
    localparam logic [3:0] ExtLsh   = 4'b0100;

    // Branch condition codes
    localparam logic [3:0] CondEq = 4'b0000;
    localparam logic [3:0] CondNe = 4'b0001;
    localparam logic [3:0] CondCs = 4'b0010;
    localparam logic [3:0] CondCc = 4'b0011;
    localparam logic [3:0] CondHi = 4'b0100;
    localparam logic [3:0] CondLs = 4'b0101;
    localparam logic [3:0] CondGt = 4'b0110;
    localparam logic [3:0] CondLe = 4'b0111;
    localparam logic [3:0] CondFs = 4'b1000;
    localparam logic [3:0] CondFc = 4'b1001;
    localparam logic [3:0] CondLo = 4'b1010;
    localparam logic [3:0] CondHs = 4'b1011;
    localparam logic [3:0] CondLt = 4'b1100;
    localparam logic [3:0] CondGe = 4'b1101;
    localparam logic [3:0] CondUc = 4'b1110;
    localparam logic [3:0] CondNv = 4'b1111;

    localparam logic [1:0] PcSrcInc  = 2'b00;
    localparam logic [1:0] PcSrcDisp = 2'b01;
    localparam logic [1:0] PcSrcReg  = 2'b10;

    localparam logic [1:0] RfSrcAlu  = 2'b00;
    localparam logic [1:0] RfSrcMem  = 2'b01;
    localparam logic [1:0] RfSrcLink = 2'b10;

    // Immediate-form ALU opcodes (B operand from the instruction)
    function automatic logic is_imm_op(input logic [3:0] op);
        return op inside {OpAdd, OpSub, OpCmp, OpAnd, OpOr, OpXor, OpMov, OpLui};
    endfunction

    // Legal ext codes for R-type ALU operations
    function automatic logic is_rtype_ext(input logic [3:0] ext);
        return ext inside {OpAdd, OpSub, OpCmp, OpAnd, OpOr, OpXor, OpMov};
    endfunction

endpackage

// File: rtl/cr16_cond_eval.sv
// cr16_cond_eval: combinational branch condition evaluator.
//   cond_i  [3:0] condition code (rdest field of the branch/jump)
//   flags_i [4:0] registered flags, [0]=C [1]=L [2]=F [3]=Z [4]=N
//   taken_o       condition holds
module cr16_cond_eval
    import cr16_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [4:0] flags_i,
    output logic       taken_o
);

    logic c, l, f, z, n;

    always_comb begin
        c = flags_i[FlagC];
        l = flags_i[FlagL];
        f = flags_i[FlagF];
        z = flags_i[FlagZ];
        n = flags_i[FlagN];
        taken_o = 1'b0;
        unique case (cond_i)
            CondEq:  taken_o = z;
            CondNe:  taken_o = ~z;
            CondCs:  taken_o = c;
            CondCc:  taken_o = ~c;
            CondHi:  taken_o = l;
            CondLs:  taken_o = ~l;
            CondGt:  taken_o = n;
            CondLe:  taken_o = ~n;
            CondFs:  taken_o = f;
            CondFc:  taken_o = ~f;
            CondLo:  taken_o = ~l & ~z;
            CondHs:  taken_o = l | z;
            CondLt:  taken_o = ~n & ~z;
            CondGe:  taken_o = n | z;
            CondUc:  taken_o = 1'b1;
            CondNv:  taken_o = 1'b0;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/cr16_ctrl_fsm.sv
// cr16_ctrl_fsm: multi-cycle CR16 control FSM (FETCH/DECODE/EXEC/MEM/BRANCH).
// Only the state register is sequential; all strobes are combinational from
// state, I_INSTR, I_FLAGS and I_MEM_ACK, and forced to 0 while I_RESET is high.
//   I_CLK, I_RESET (async, active-high), I_RUN (leave FETCH), I_INSTR (IR),
//   I_FLAGS (flag register), I_MEM_ACK (memory done)
//   O_MEM_REQ/O_MEM_WE/O_ADDR_SRC  memory port control
//   O_IR_EN, O_PC_EN, O_PC_SRC     IR and PC control
//   O_RF_WE, O_RF_SRC, O_ALU_IMM   register file / ALU control
//   O_FLAGS_EN, O_ILLEGAL, O_STATE flag enable, illegal pulse, debug state
module cr16_ctrl_fsm
    import cr16_pkg::*;
#(
    parameter int unsigned P_FLAG_WIDTH  = 5,
    parameter int unsigned P_INSTR_WIDTH = 16
) (
    input  logic                     I_CLK,
    input  logic                     I_RESET,
    input  logic                     I_RUN,
    input  logic [P_INSTR_WIDTH-1:0] I_INSTR,
    input  logic [P_FLAG_WIDTH-1:0]  I_FLAGS,
    input  logic                     I_MEM_ACK,
    output logic                     O_MEM_REQ,
    output logic                     O_MEM_WE,
    output logic                     O_ADDR_SRC,
    output logic                     O_IR_EN,
    output logic                     O_PC_EN,
    output logic [1:0]               O_PC_SRC,
    output logic                     O_RF_WE,
    output logic [1:0]               O_RF_SRC,
    output logic                     O_ALU_IMM,
    output logic                     O_FLAGS_EN,
    output logic                     O_ILLEGAL,
    output logic [2:0]               O_STATE
);

    state_e state_q, state_d;

    logic [3:0] op, ext, cond;
    logic       is_alu, is_imm, is_lshi, is_cmp, is_flag_op;
    logic       is_load, is_stor, is_bcond, is_jcond, is_jal;
    logic       taken;
    logic       unused_rsrc;

    assign op   = I_INSTR[15:12];
    assign cond = I_INSTR[11:8];
    assign ext  = I_INSTR[7:4];
    // Rsrc/imm is a datapath field only
    assign unused_rsrc = ^I_INSTR[3:0];

    cr16_cond_eval u_cond_eval (
        .cond_i  (cond),
        .flags_i (I_FLAGS[4:0]),
        .taken_o (taken)
    );

    // Instruction class decode
    always_comb begin
        is_imm     = is_imm_op(op);
        is_lshi    = (op == OpShift) && (ext[3:1] == 3'b000);
        is_alu     = ((op == OpRtype) && is_rtype_ext(ext)) || is_imm || is_lshi ||
                     ((op == OpShift) && (ext == ExtLsh));
        is_cmp     = ((op == OpRtype) && (ext == OpCmp)) || (op == OpCmp);
        is_flag_op = ((op == OpRtype) && (ext inside {OpAdd, OpSub, OpCmp})) ||
                     (op inside {OpAdd, OpSub, OpCmp});
        is_load    = (op == OpMemJ) && (ext == ExtLoad);
        is_stor    = (op == OpMemJ) && (ext == ExtStor);
        is_jcond   = (op == OpMemJ) && (ext == ExtJcond);
        is_jal     = (op == OpMemJ) && (ext == ExtJal);
        is_bcond   = (op == OpBcond);
    end

    always_comb begin
        state_d    = state_q;
        O_MEM_REQ  = 1'b0;
        O_MEM_WE   = 1'b0;
        O_ADDR_SRC = 1'b0;
        O_IR_EN    = 1'b0;
        O_PC_EN    = 1'b0;
        O_PC_SRC   = PcSrcInc;
        O_RF_WE    = 1'b0;
        O_RF_SRC   = RfSrcAlu;
        O_ALU_IMM  = 1'b0;
        O_FLAGS_EN = 1'b0;
        O_ILLEGAL  = 1'b0;
        O_STATE    = state_q;

        unique case (state_q)
            StFetch: begin
                // Request tracks I_RUN; dropping I_RUN abandons the fetch
                if (I_RUN) begin
                    O_MEM_REQ = 1'b1;
                    if (I_MEM_ACK) begin
                        O_IR_EN = 1'b1;
                        state_d = StDecode;
                    end
                end
            end
            StDecode: begin
                if (is_alu) begin
                    state_d = StExec;
                end else if (is_load || is_stor) begin
                    state_d = StMem;
                end else if (is_bcond || is_jcond || is_jal) begin
                    state_d = StBranch;
                end else begin
                    // Skip the undecodable instruction
                    O_ILLEGAL = 1'b1;
                    O_PC_EN   = 1'b1;
                    state_d   = StFetch;
                end
            end
            StExec: begin
                O_PC_EN    = 1'b1;
                O_ALU_IMM  = is_imm || is_lshi;
                O_RF_WE    = ~is_cmp;
                O_FLAGS_EN = is_flag_op;
                state_d    = StFetch;
            end
            StMem: begin
                O_MEM_REQ  = 1'b1;
                O_ADDR_SRC = 1'b1;
                O_MEM_WE   = is_stor;
                if (I_MEM_ACK) begin
                    O_PC_EN = 1'b1;
                    if (is_load) begin
                        O_RF_WE  = 1'b1;
                        O_RF_SRC = RfSrcMem;
                    end
                    state_d = StFetch;
                end
            end
            StBranch: begin
                O_PC_EN = 1'b1;
                if (is_jal) begin
                    O_RF_WE  = 1'b1;
                    O_RF_SRC = RfSrcLink;
                    O_PC_SRC = PcSrcReg;
                end else if (taken) begin
                    O_PC_SRC = is_bcond ? PcSrcDisp : PcSrcReg;
                end
                state_d = StFetch;
            end
            default: state_d = StFetch;
        endcase

        if (I_RESET) begin
            O_MEM_REQ  = 1'b0;
            O_MEM_WE   = 1'b0;
            O_ADDR_SRC = 1'b0;
            O_IR_EN    = 1'b0;
            O_PC_EN    = 1'b0;
            O_PC_SRC   = 2'b00;
            O_RF_WE    = 1'b0;
            O_RF_SRC   = 2'b00;
            O_ALU_IMM  = 1'b0;
            O_FLAGS_EN = 1'b0;
            O_ILLEGAL  = 1'b0;
            O_STATE    = 3'd0;
        end
    end

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_cr16_ctrl_fsm.sv
// Directed testbench for cr16_ctrl_fsm with hand-computed output vectors.
module tb_cr16_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [15:0] instr;
    logic [4:0]  flags;
    logic        ack;

    logic        mem_req, mem_we, addr_src, ir_en, pc_en, rf_we, alu_imm, flags_en, illegal;
    logic [1:0]  pc_src, rf_src;
    logic [2:0]  state;
    logic [12:0] outs;

    int n_checks = 0;
    int n_fail   = 0;

    // Output vector bit positions
    localparam logic [12:0] MREQ = 13'h1000;
    localparam logic [12:0] MWE  = 13'h0800;
    localparam logic [12:0] ASRC = 13'h0400;
    localparam logic [12:0] IREN = 13'h0200;
    localparam logic [12:0] PCEN = 13'h0100;
    localparam logic [12:0] PC10 = 13'h0080;
    localparam logic [12:0] PC01 = 13'h0040;
    localparam logic [12:0] RFWE = 13'h0020;
    localparam logic [12:0] RF10 = 13'h0010;
    localparam logic [12:0] RF01 = 13'h0008;
    localparam logic [12:0] AIMM = 13'h0004;
    localparam logic [12:0] FEN  = 13'h0002;
    localparam logic [12:0] ILL  = 13'h0001;
    localparam logic [12:0] NONE = 13'h0000;

    always #5 clk = ~clk;

    cr16_ctrl_fsm dut (
        .I_CLK      (clk),
        .I_RESET    (rst),
        .I_RUN      (run),
        .I_INSTR    (instr),
        .I_FLAGS    (flags),
        .I_MEM_ACK  (ack),
        .O_MEM_REQ  (mem_req),
        .O_MEM_WE   (mem_we),
        .O_ADDR_SRC (addr_src),
        .O_IR_EN    (ir_en),
        .O_PC_EN    (pc_en),
        .O_PC_SRC   (pc_src),
        .O_RF_WE    (rf_we),
        .O_RF_SRC   (rf_src),
        .O_ALU_IMM  (alu_imm),
        .O_FLAGS_EN (flags_en),
        .O_ILLEGAL  (illegal),
        .O_STATE    (state)
    );

    assign outs = {mem_req, mem_we, addr_src, ir_en, pc_en, pc_src, rf_we, rf_src,
                   alu_imm, flags_en, illegal};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply inputs for one cycle, check outputs and state mid-cycle, then advance.
    task automatic cyc(input string tag, input logic [15:0] i, input logic r, input logic a,
                       input logic [4:0] f, input logic [12:0] exp, input logic [2:0] exp_st);
        instr = i;
        run   = r;
        ack   = a;
        flags = f;
        #1;
        check({tag, " outs"}, {19'd0, outs}, {19'd0, exp});
        check({tag, " state"}, {29'd0, state}, {29'd0, exp_st});
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst   = 1'b1;
        run   = 1'b1;
        ack   = 1'b1;
        instr = 16'h0152;
        flags = 5'h1f;
        #3;
        check("reset outs", {19'd0, outs}, 32'd0);
        check("reset state", {29'd0, state}, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        // STOR, then reset while waiting in MEM
        cyc("stor fetch", 16'h4243, 1'b1, 1'b1, 5'h00, MREQ | IREN, 3'd0);
        cyc("stor decode", 16'h4243, 1'b1, 1'b0, 5'h00, NONE, 3'd1);
        ack = 1'b0;
        #1;
        check("stor mem wait", {19'd0, outs}, {19'd0, MREQ | MWE | ASRC});
        check("stor mem state", {29'd0, state}, 32'd3);
        rst = 1'b1;
        #1;
        check("mid-mem reset outs", {19'd0, outs}, 32'd0);
        check("mid-mem reset state", {29'd0, state}, 32'd0);
        rst = 1'b0;
        #1;
        check("post-reset fetch", {19'd0, outs}, {19'd0, MREQ});
        check("post-reset state", {29'd0, state}, 32'd0);
        @(posedge clk);
        #2;

        // ADD: 3 cycles, sets flags
        cyc("add fetch", 16'h0152, 1'b1, 1'b1, 5'h00, MREQ | IREN, 3'd0);
        cyc("add decode", 16'h0152, 1'b1, 1'b0, 5'h00, NONE, 3'd1);
        cyc("add exec", 16'h0152, 1'b1, 1'b0, 5'h00, RFWE | FEN | PCEN, 3'd2);

        // CMPI: flags only, no register write
        cyc("cmpi fetch", 16'hB105, 1'b1, 1'b1, 5'h00, MREQ | IREN, 3'd0);
        cyc("cmpi decode", 16'hB105, 1'b1, 1'b0, 5'h00, NONE, 3'd1);
        cyc("cmpi exec", 16'hB105, 1'b1, 1'b0, 5'h00, PCEN | AIMM | FEN, 3'd2);

        // BEQ taken (Z=1) and not taken (flags=0)
        cyc("beq1 fetch", 16'hC0F0, 1'b1, 1'b1, 5'h08, MREQ | IREN, 3'd0);
        cyc("beq1 decode", 16'hC0F0, 1'b1, 1'b0, 5'h08, NONE, 3'd1);
        cyc("beq taken", 16'hC0F0, 1'b1, 1'b0, 5'h08, PCEN | PC01, 3'd4);
        cyc("beq2 fetch", 16'hC0F0, 1'b1, 1'b1, 5'h00, MREQ | IREN, 3'd0);
        cyc("beq2 decode", 16'hC0F0, 1'b1, 1'b0, 5'h00, NONE, 3'd1);
        cyc("beq not taken", 16'hC0F0, 1'b1, 1'b0, 5'h00, PCEN, 3'd4);

        // BLO with L=0,Z=0 is taken; with Z=1 not taken
        cyc("blo fetch", 16'hCA05, 1'b1, 1'b1, 5'h00, MREQ | IREN, 3'd0);
        cyc("blo decode", 16'hCA05, 1'b1, 1'b0, 5'h00, NONE, 3'd1);
        cyc("blo taken", 16'hCA05, 1'b1, 1'b0, 5'h00, PCEN | PC01, 3'd4);
        cyc("blo2 fetch", 16'hCA05, 1'b1, 1'b1, 5'h08, MREQ | IREN, 3'd0);
        cyc("blo2 decode", 16'hCA05, 1'b1, 1'b0, 5'h08, NONE, 3'd1);
        cyc("blo not taken", 16'hCA05, 1'b1, 1'b0, 5'h08, PCEN, 3'd4);

        // LOAD with three wait cycles
        cyc("load fetch", 16'h4203, 1'b1, 1'b1, 5'h00, MREQ | IREN, 3'd0);
        cyc("load decode", 16'h4203, 1'b1, 1'b0, 5'h00, NONE, 3'd1);
        cyc("load wait1", 16'h4203, 1'b1, 1'b0, 5'h00, MREQ | ASRC, 3'd3);
        cyc("load wait2", 16'h4203, 1'b1, 1'b0, 5'h00, MREQ | ASRC, 3'd3);
        cyc("load wait3", 16'h4203, 1'b1, 1'b0, 5'h00, MREQ | ASRC, 3'd3);
        cyc("load ack", 16'h4203, 1'b1, 1'b1, 5'h00, MREQ | ASRC | PCEN | RFWE | RF01, 3'd3);

        // STOR zero-wait
        cyc("stor2 fetch", 16'h4243, 1'b1, 1'b1, 5'h00, MREQ | IREN, 3'd0);
        cyc("stor2 decode", 16'h4243, 1'b1, 1'b0, 5'h00, NONE, 3'd1);
        cyc("stor2 ack", 16'h4243, 1'b1, 1'b1, 5'h00, MREQ | MWE | ASRC | PCEN, 3'd3);

        // JAL, Jcond never, Jcond always
        cyc("jal fetch", 16'h4E83, 1'b1, 1'b1, 5'h00, MREQ | IREN, 3'd0);
        cyc("jal decode", 16'h4E83, 1'b1, 1'b0, 5'h00, NONE, 3'd1);
        cyc("jal branch", 16'h4E83, 1'b1, 1'b0, 5'h00, PCEN | PC10 | RFWE | RF10, 3'd4);
        cyc("jnv fetch", 16'h4FC3, 1'b1, 1'b1, 5'h1f, MREQ | IREN, 3'd0);
        cyc("jnv decode", 16'h4FC3, 1'b1, 1'b0, 5'h1f, NONE, 3'd1);
        cyc("jnv branch", 16'h4FC3, 1'b1, 1'b0, 5'h1f, PCEN, 3'd4);
        cyc("juc fetch", 16'h4EC3, 1'b1, 1'b1, 5'h00, MREQ | IREN, 3'd0);
        cyc("juc decode", 16'h4EC3, 1'b1, 1'b0, 5'h00, NONE, 3'd1);
        cyc("juc branch", 16'h4EC3, 1'b1, 1'b0, 5'h00, PCEN | PC10, 3'd4);

        // LSHI uses the immediate, writes Rdest, no flags
        cyc("lshi fetch", 16'h8312, 1'b1, 1'b1, 5'h00, MREQ | IREN, 3'd0);
        cyc("lshi decode", 16'h8312, 1'b1, 1'b0, 5'h00, NONE, 3'd1);
        cyc("lshi exec", 16'h8312, 1'b1, 1'b0, 5'h00, PCEN | AIMM | RFWE, 3'd2);

        // Illegal instruction, then idle with I_RUN low
        cyc("ill fetch", 16'h0000, 1'b1, 1'b1, 5'h00, MREQ | IREN, 3'd0);
        cyc("ill decode", 16'h0000, 1'b1, 1'b0, 5'h00, ILL | PCEN, 3'd1);
        cyc("idle1", 16'h0000, 1'b0, 1'b0, 5'h00, NONE, 3'd0);
        cyc("idle ack", 16'h0000, 1'b0, 1'b1, 5'h00, NONE, 3'd0);
        cyc("idle2", 16'h0000, 1'b0, 1'b0, 5'h00, NONE, 3'd0);
        cyc("resume fetch", 16'h0152, 1'b1, 1'b0, 5'h00, MREQ, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
